sweep_ctrl: RTL and testbench

SWEEP_CTRL -- requirements
Module: sweep_ctrl

---
 rtl/sweep_pkg.sv | 19 +
 rtl/sweep_dp.sv | 39 +++
 rtl/sweep_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sweep_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// ---------------------------------------------------------------------------
// sweep_pkg
// Shared types and constants for the sweep controller.
//   state_t : FSM state encoding (IDLE, UP, HOLD, DOWN, DONE)
//   HOLD_W  : width of the hold-phase cycle counter (covers HOLD_CYCLES 1..255)
// ---------------------------------------------------------------------------
package sweep_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UP   = 3'd1,
        S_HOLD = 3'd2,
        S_DOWN = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int HOLD_W = 8;

endpackage

// File: rtl/sweep_dp.sv
// ---------------------------------------------------------------------------
// sweep_dp
// WIDTH-bit up/down counter with synchronous load, used as the sweep datapath.
// Ports:
//   clk      - clock (rising edge)
//   rst      - synchronous active-high reset, clears the counter
//   load     - load load_val this cycle (has priority over stepping)
//   load_val - value to load
//   step_en  - step the counter by one this cycle
//   up       - step direction: 1 = increment, 0 = decrement
//   count    - current counter value
// ---------------------------------------------------------------------------
module sweep_dp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step_en,
    input  logic             up,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (step_en) begin
            count_q <= up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sweep_ctrl.sv
// ---------------------------------------------------------------------------
// sweep_ctrl
// Triangle sweep controller: counts lo..hi, holds at hi for HOLD_CYCLES extra
// cycles, counts back down to lo, and repeats for the requested number of
// sweeps. Later sweeps start at lo+1 so lo is not emitted twice.
// Ports:
//   clk    - clock (rising edge)
//   rst    - synchronous active-high reset
//   start  - run request, only looked at in IDLE
//   pause  - (only with SWEEP_PAUSE_EN) freezes the run while busy
//   lo, hi - sweep limits, latched on an accepted start
//   sweeps - number of up/down sweeps, latched on an accepted start
//   count  - current counter value
//   dir    - 1 while counting up or holding, 0 otherwise
//   busy   - high in UP, HOLD and DOWN
//   done   - one-cycle pulse (the DONE state) when a run completes
//   err    - one-cycle pulse after a rejected start
// Build option: define SWEEP_PAUSE_EN to add the pause input.
// ---------------------------------------------------------------------------
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int SWEEPS_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
`ifdef SWEEP_PAUSE_EN
    input  logic                pause,
`endif
    input  logic [WIDTH-1:0]    lo,
    input  logic [WIDTH-1:0]    hi,
    input  logic [SWEEPS_W-1:0] sweeps,
    output logic [WIDTH-1:0]    count,
    output logic                dir,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [SWEEPS_W-1:0] sweeps_q, sweeps_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                err_q, err_d;

    logic                dp_load;
    logic [WIDTH-1:0]    dp_val;
    logic                dp_step;
    logic                dp_up;
    logic                run_active;
    logic                freeze;

    assign run_active = (state_q == S_UP) || (state_q == S_HOLD) || (state_q == S_DOWN);

`ifdef SWEEP_PAUSE_EN
    // Pause only has an effect mid-run; IDLE and DONE proceed normally.
    assign freeze = pause && run_active;
`else
    assign freeze = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            sweeps_q <= '0;
            hold_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            sweeps_q <= sweeps_d;
            hold_q   <= hold_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        sweeps_d = sweeps_q;
        hold_d   = hold_q;
        err_d    = 1'b0;
        dp_load  = 1'b0;
        dp_val   = lo_q;
        dp_step  = 1'b0;
        dp_up    = 1'b1;

        if (!freeze) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if ((lo < hi) && (sweeps != '0)) begin
                            lo_d     = lo;
                            hi_d     = hi;
                            sweeps_d = sweeps;
                            dp_load  = 1'b1;
                            dp_val   = lo;
                            state_d  = S_UP;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_UP: begin
                    // hi itself is shown once in UP; HOLD adds the extra copies.
                    if (count == hi_q) begin
                        hold_d  = '0;
                        state_d = S_HOLD;
                    end else begin
                        dp_step = 1'b1;
                        dp_up   = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                        dp_load = 1'b1;
                        dp_val  = hi_q - WIDTH'(1);
                        state_d = S_DOWN;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                S_DOWN: begin
                    if (count == lo_q) begin
                        sweeps_d = sweeps_q - SWEEPS_W'(1);
                        if (sweeps_q == SWEEPS_W'(1)) begin
                            // count already sits at lo, which DONE must show.
                            state_d = S_DONE;
                        end else begin
                            dp_load = 1'b1;
                            dp_val  = lo_q + WIDTH'(1);
                            state_d = S_UP;
                        end
                    end else begin
                        dp_step = 1'b1;
                        dp_up   = 1'b0;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    sweep_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (dp_load),
        .load_val (dp_val),
        .step_en  (dp_step),
        .up       (dp_up),
        .count    (count)
    );

    assign busy = run_active;
    assign dir  = (state_q == S_UP) || (state_q == S_HOLD);
    assign done = (state_q == S_DONE);
    assign err  = err_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sweep_ctrl
// Self-checking bench for sweep_ctrl. Expected per-cycle outputs are pushed
// to a queue when a run is started and popped one per clock as the DUT runs.
// Define SWEEP_PAUSE_EN to also exercise the pause input.
// ---------------------------------------------------------------------------
module tb_sweep_ctrl;

    localparam int WIDTH       = 8;
    localparam int HOLD_CYCLES = 4;
    localparam int SWEEPS_W    = 4;

    typedef struct {
        logic [WIDTH-1:0] count;
        logic             busy;
        logic             done;
        logic             err;
        logic             dir;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                pause = 1'b0;
    logic [WIDTH-1:0]    lo = '0;
    logic [WIDTH-1:0]    hi = '0;
    logic [SWEEPS_W-1:0] sweeps = '0;
    logic [WIDTH-1:0]    count;
    logic                dir, busy, done, err;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   model_count = 0;

    always #5 clk = ~clk;

    sweep_ctrl #(
        .WIDTH       (WIDTH),
        .HOLD_CYCLES (HOLD_CYCLES),
        .SWEEPS_W    (SWEEPS_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
`ifdef SWEEP_PAUSE_EN
        .pause  (pause),
`endif
        .lo     (lo),
        .hi     (hi),
        .sweeps (sweeps),
        .count  (count),
        .dir    (dir),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, expv, $time);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic b, input logic d, input logic e, input logic r);
        exp_t x;
        x.count = WIDTH'(c);
        x.busy  = b;
        x.done  = d;
        x.err   = e;
        x.dir   = r;
        exp_q.push_back(x);
    endtask

    // Reference model: expected outputs for the cycles following a start.
    task automatic build(input int l, input int h, input int s, input int pause_at, input int pause_len);
        if (l < h && s != 0) begin
            for (int sw = 0; sw < s; sw++) begin
                for (int c = (sw == 0) ? l : l + 1; c <= h; c++) push(c, 1, 0, 0, 1);
                for (int k = 0; k < HOLD_CYCLES; k++) push(h, 1, 0, 0, 1);
                for (int c = h - 1; c >= l; c--) push(c, 1, 0, 0, 0);
            end
            push(l, 0, 1, 0, 0);
            push(l, 0, 0, 0, 0);
            model_count = l;
        end else begin
            push(model_count, 0, 0, 1, 0);
            push(model_count, 0, 0, 0, 0);
        end
        // A paused cycle simply repeats the outputs of the cycle it froze.
        if (pause_len > 0) begin
            exp_t x;
            x = exp_q[pause_at];
            for (int k = 0; k < pause_len; k++) exp_q.insert(pause_at, x);
        end
    endtask

    task automatic check_pop(input string name, input int idx);
        exp_t x;
        x = exp_q.pop_front();
        chk($sformatf("%s[%0d].count", name, idx), 32'(count), 32'(x.count));
        chk($sformatf("%s[%0d].busy",  name, idx), 32'(busy),  32'(x.busy));
        chk($sformatf("%s[%0d].done",  name, idx), 32'(done),  32'(x.done));
        chk($sformatf("%s[%0d].err",   name, idx), 32'(err),   32'(x.err));
        chk($sformatf("%s[%0d].dir",   name, idx), 32'(dir),   32'(x.dir));
    endtask

    // Start a run and compare every produced cycle against the model.
    // inject_at >= 0 drives a fresh start with new limits mid-run.
    task automatic run(input string name, input int l, input int h, input int s,
                       input int inject_at, input int pause_at, input int pause_len);
        int idx;
        int bad0;
        bad0 = bad;
        build(l, h, s, pause_at, pause_len);
        lo     = WIDTH'(l);
        hi     = WIDTH'(h);
        sweeps = SWEEPS_W'(s);
        start  = 1'b1;
        idx    = 0;
        while (exp_q.size() > 0) begin
            step();
            check_pop(name, idx);
            start = (idx == inject_at);
            if (idx == inject_at) begin
                lo     = WIDTH'(7);
                hi     = WIDTH'(9);
                sweeps = SWEEPS_W'(3);
            end
            pause = (pause_len > 0) && (idx >= pause_at) && (idx < pause_at + pause_len);
            idx++;
        end
        start = 1'b0;
        pause = 1'b0;
        $display("run %s lo=%0d hi=%0d sweeps=%0d cycles=%0d new_bad=%0d", name, l, h, s, idx, bad - bad0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) step();
        chk("rst.count", 32'(count), 0);
        chk("rst.busy",  32'(busy),  0);
        chk("rst.done",  32'(done),  0);
        chk("rst.err",   32'(err),   0);
        chk("rst.dir",   32'(dir),   0);
        rst = 1'b0;
        model_count = 0;
        step();
        $display("reset check done");

        run("basic",    2, 5, 1, -1, 0, 0);
        run("repeat",   0, 2, 2, -1, 0, 0);
        run("rej_eq",   5, 5, 3, -1, 0, 0);
        run("rej_zero", 1, 3, 0, -1, 0, 0);
        run("rej_inv",  9, 4, 1, -1, 0, 0);
        run("ignore",   3, 6, 2,  4, 0, 0);
        run("narrow",   4, 5, 3, -1, 0, 0);
`ifdef SWEEP_PAUSE_EN
        run("pause",    1, 6, 1, -1, 2, 3);
        run("pause_hold", 2, 4, 1, -1, 4, 2);
`endif

        // Reset mid-run while in HOLD: no done pulse afterwards.
        build(2, 5, 1, 0, 0);
        lo = 8'd2; hi = 8'd5; sweeps = 4'd1; start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_pop("abort", i);
            start = 1'b0;
        end
        rst = 1'b1;
        step();
        chk("abort.count", 32'(count), 0);
        chk("abort.busy",  32'(busy),  0);
        chk("abort.done",  32'(done),  0);
        rst = 1'b0;
        exp_q.delete();
        model_count = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("abort.nodone", 32'(done), 0);
            chk("abort.idle",   32'(busy), 0);
        end
        $display("reset mid-run check done");

        // Back to normal operation after the abort.
        run("after_abort", 1, 3, 1, -1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
